fc_fold_sequencer: RTL

- Controller for the folded fully-connected datapath. It accepts one input activation vector and steps the fold index through 0..FOLD-1.
- For each fold it waits a fixed pipeline latency for the MAC/ReLU stage, then captures that fold's DIM_OUT/FOLD ReLU outputs into an output buffer.
- When the buffer holds the full DIM_OUT-wide result, it presents the result on a valid/ready interface.
- It sits between the input-vector source and the downstream layer, and drives the weight/bias fold select.

---
 rtl/fc_fold_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/fc_fold_sequencer.sv
// Fold sequencer for the folded fully-connected datapath: latches one input vector,
// walks fold_idx through every fold, captures each ReLU slice and presents the full result.
module fc_fold_sequencer #(
  parameter int DIM_IN   = 4,
  parameter int DIM_OUT  = 4,
  parameter int FOLD     = 2,
  parameter int INWD     = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DIM_IN*INWD-1:0]                 in_data,
  output logic [DIM_IN*INWD-1:0]                 act_data,
  output logic [((FOLD > 1) ? $clog2(FOLD) : 1)-1:0] fold_idx,
  output logic                                   dp_en,
  input  logic [(DIM_OUT/FOLD)*INWD-1:0]         relu_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DIM_OUT*INWD-1:0]                out_data,
  output logic                                   busy
);

  localparam int W  = DIM_OUT / FOLD;
  localparam int SW = W * INWD;
  localparam int FW = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int CW = (PIPE_LAT >= 1) ? $clog2(PIPE_LAT + 1) : 1;

  if ((DIM_OUT % FOLD) != 0) begin : g_bad_fold
    $error("fc_fold_sequencer: DIM_OUT must be divisible by FOLD");
  end
  if (PIPE_LAT < 1) begin : g_bad_lat
    $error("fc_fold_sequencer: PIPE_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic            capture;
  logic            last_fold;

  // The capture cycle is the last of the PIPE_LAT+1 cycles spent on each fold.
  assign capture   = (state == S_WAIT) && (wait_cnt == CW'(PIPE_LAT));
  assign last_fold = (fold_idx == FW'(FOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_WAIT;
      S_WAIT: if (capture && last_fold) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    dp_en     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = !rst;
        busy     = 1'b0;
      end
      S_WAIT: dp_en = 1'b1;
      S_DONE: out_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Activation latch, fold/wait counters and result buffer; reset clears the partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data <= '0;
      out_data <= '0;
      fold_idx <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            act_data <= in_data;
            fold_idx <= '0;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (capture) begin
            for (int f = 0; f < FOLD; f++) begin
              if (fold_idx == FW'(f)) out_data[f*SW +: SW] <= relu_in;
            end
            if (!last_fold) fold_idx <= fold_idx + FW'(1);
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
